// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - main control FSM for the multicycle MIPS core
//
// Sequences the shared datapath through fetch, decode, execute, memory
// and writeback. It waits on mem_ready for variable-latency memory. A
// watchdog bounds memory waits, and a sticky TRAP state catches illegal
// instructions and memory timeouts.
//
// Optional feature macro: BNE_BLTZ_EN (bne becomes a legal branch with
// pcen = ~zero; when undefined, bne decodes as illegal).
//
// Parameters:
//   ALUCTRL_W    alucontrol width (>=3, bits above [2] are driven 0)
//   TIMEOUT_CYC  consecutive memory wait cycles before trapping (1..255)
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-low reset
//   opcode, funct            instruction fields from the IR
//   zero                     ALU zero flag
//   mem_ready                memory completes the current access this cycle
//   iord .. alusrca          single-bit datapath controls
//   alusrcb, pcsrc           ALU B / PC source selects
//   pcen                     PC write enable
//   alucontrol               ALU operation
//   state                    current state code (debug)
//   illegal, mem_timeout     sticky fault flags
module mc_control_fsm #(
    parameter int ALUCTRL_W   = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 iord,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 regdst,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic [3:0]           state,
    output logic                 illegal,
    output logic                 mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_BLTZ_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Last watchdog count that may still wait; one more idle cycle traps.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] wdog_q, wdog_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic       mem_wait;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default:                                                funct_legal = 1'b0;
        endcase
    endfunction

    // Unsupported functs fall back to add; the FSM traps on them anyway.
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    // Next-state, watchdog and sticky flag logic.
    always_comb begin
        state_d   = state_q;
        wdog_d    = 8'd0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;

        // Only the three memory-handshake states can stall.
        case (state_q)
            S_FETCH, S_MEMRD, S_MEMWR: mem_wait = !mem_ready;
            default:                   mem_wait = 1'b0;
        endcase

        if (mem_wait && (wdog_q == WDOG_LAST)) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
        end else begin
            if (mem_wait) begin
                wdog_d = wdog_q + 8'd1;
            end
            case (state_q)
                S_FETCH:  if (mem_ready) state_d = S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
`ifdef BNE_BLTZ_EN
                        OP_BNE:       state_d = S_BRANCH;
`endif
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default: begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                // IR is stable past FETCH, so opcode still selects lw/sw here.
                S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                S_MEMWB:  state_d = S_FETCH;
                S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                S_EXEC: begin
                    if (funct_legal(funct)) begin
                        state_d = S_ALUWB;
                    end else begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                end
                S_ALUWB:  state_d = S_FETCH;
                S_BRANCH: state_d = S_FETCH;
                S_ADDIEX: state_d = S_ADDIWB;
                S_ADDIWB: state_d = S_FETCH;
                S_JUMP:   state_d = S_FETCH;
                S_TRAP:   state_d = S_TRAP;
                default:  state_d = S_TRAP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wdog_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Output decode. Everything is held at 0 while reset is asserted, so an
    // aborted instruction can never issue a write in the reset cycle.
    logic [2:0] alu3;
    logic       take;

    always_comb begin
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        pcen        = 1'b0;
        alu3        = 3'b000;
        state       = 4'd0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;

`ifdef BNE_BLTZ_EN
        take = (opcode == OP_BNE) ? !zero : zero;
`else
        take = zero;
`endif

        if (reset) begin
            state       = state_q;
            illegal     = illegal_q;
            mem_timeout = timeout_q;
            alu3        = ALU_ADD;
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcen    = mem_ready;
                end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    alu3    = funct_alu(funct);
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    alu3    = ALU_SUB;
                    pcsrc   = 2'b01;
                    pcen    = take;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: regwrite = 1'b1;
                S_JUMP: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                default: alu3 = 3'b000;
            endcase
        end

        alucontrol = ALUCTRL_W'(alu3);
    end

endmodule
